// File: rtl/parser_input_arbiter.sv
// Packet-granular round-robin arbiter sharing the parser receive port among NUM_SRC sources.
// Holds the grant until the owner's last word is accepted; keeps per-source packet counts and a length error flag.
module parser_input_arbiter #(
  parameter int unsigned NUM_SRC   = 4,
  parameter int unsigned MAX_WORDS = 12
) (
  input  logic                    clk,
  input  logic                    reset_b,
  input  logic [NUM_SRC*32-1:0]   src_data,
  input  logic [NUM_SRC-1:0]      src_val,
  input  logic [NUM_SRC-1:0]      src_last,
  output logic [NUM_SRC-1:0]      src_ready,
  output logic [31:0]             dataIn,
  output logic                    dataIn_val,
  output logic                    dataIN_last,
  input  logic                    dataIn_ready,
  output logic                    grant_valid,
  output logic [2:0]              grant_idx,
  output logic                    pkt_done,
  output logic [NUM_SRC*16-1:0]   pkt_count,
  output logic                    len_err
);

  localparam int unsigned WORD_W = 32;
  localparam int unsigned IDX_W  = 3;
  localparam int unsigned CNT_W  = 16;
  localparam int unsigned WCNT_W = $clog2(MAX_WORDS + 2);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_e;

  state_e                         state_q, state_d;
  logic [IDX_W-1:0]               grant_idx_q, grant_idx_d;
  logic [IDX_W-1:0]               last_grant_q, last_grant_d;
  logic                           grant_valid_q, grant_valid_d;
  logic [WCNT_W-1:0]              wcnt_q, wcnt_d;
  logic                           pkt_done_q, pkt_done_d;
  logic                           len_err_q, len_err_d;
  logic [NUM_SRC-1:0][CNT_W-1:0]  pkt_count_q, pkt_count_d;

  logic [WORD_W-1:0]              sel_data;
  logic                           sel_val;
  logic                           sel_last;
  logic                           beat;
  logic                           rr_found;
  logic [IDX_W-1:0]               rr_idx;

  // Word, valid and last of the currently granted source
  always_comb begin
    sel_data = '0;
    sel_val  = 1'b0;
    sel_last = 1'b0;
    for (int unsigned k = 0; k < NUM_SRC; k++) begin
      if (grant_idx_q == IDX_W'(k)) begin
        sel_data = src_data[k*WORD_W +: WORD_W];
        sel_val  = src_val[k];
        sel_last = src_last[k];
      end
    end
  end

  // Round-robin pick: first requester above last_grant, otherwise first requester from index 0
  always_comb begin
    rr_found = 1'b0;
    rr_idx   = '0;
    for (int unsigned k = 0; k < NUM_SRC; k++) begin
      if (!rr_found && src_val[k] && (IDX_W'(k) > last_grant_q)) begin
        rr_found = 1'b1;
        rr_idx   = IDX_W'(k);
      end
    end
    for (int unsigned k = 0; k < NUM_SRC; k++) begin
      if (!rr_found && src_val[k]) begin
        rr_found = 1'b1;
        rr_idx   = IDX_W'(k);
      end
    end
  end

  assign beat = (state_q == ST_LOCKED) && sel_val && dataIn_ready;

  // State register
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d       = state_q;
    grant_idx_d   = grant_idx_q;
    last_grant_d  = last_grant_q;
    grant_valid_d = grant_valid_q;
    wcnt_d        = wcnt_q;
    pkt_done_d    = 1'b0;
    len_err_d     = len_err_q;
    pkt_count_d   = pkt_count_q;
    case (state_q)
      ST_IDLE: begin
        if (rr_found) begin
          grant_idx_d   = rr_idx;
          grant_valid_d = 1'b1;
          wcnt_d        = '0;
          state_d       = ST_LOCKED;
        end
      end
      ST_LOCKED: begin
        if (beat) begin
          // A word beyond MAX_WORDS flags the packet but is still forwarded
          if (wcnt_q >= WCNT_W'(MAX_WORDS)) begin
            len_err_d = 1'b1;
          end
          if (wcnt_q != WCNT_W'(MAX_WORDS + 1)) begin
            wcnt_d = wcnt_q + WCNT_W'(1);
          end
          if (sel_last) begin
            pkt_done_d    = 1'b1;
            last_grant_d  = grant_idx_q;
            grant_valid_d = 1'b0;
            state_d       = ST_IDLE;
            for (int unsigned k = 0; k < NUM_SRC; k++) begin
              if (grant_idx_q == IDX_W'(k)) begin
                pkt_count_d[k] = pkt_count_q[k] + CNT_W'(1);
              end
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      grant_idx_q   <= '0;
      last_grant_q  <= IDX_W'(NUM_SRC - 1);
      grant_valid_q <= 1'b0;
      wcnt_q        <= '0;
      pkt_done_q    <= 1'b0;
      len_err_q     <= 1'b0;
      pkt_count_q   <= '0;
    end else begin
      grant_idx_q   <= grant_idx_d;
      last_grant_q  <= last_grant_d;
      grant_valid_q <= grant_valid_d;
      wcnt_q        <= wcnt_d;
      pkt_done_q    <= pkt_done_d;
      len_err_q     <= len_err_d;
      pkt_count_q   <= pkt_count_d;
    end
  end

  // Zero-latency pass-through of the owner's stream while locked
  always_comb begin
    dataIn      = '0;
    dataIn_val  = 1'b0;
    dataIN_last = 1'b0;
    src_ready   = '0;
    if (state_q == ST_LOCKED) begin
      dataIn      = sel_data;
      dataIn_val  = sel_val;
      dataIN_last = sel_last && sel_val;
      for (int unsigned k = 0; k < NUM_SRC; k++) begin
        if (grant_idx_q == IDX_W'(k)) begin
          src_ready[k] = dataIn_ready;
        end
      end
    end
  end

  assign grant_valid = grant_valid_q;
  assign grant_idx   = grant_idx_q;
  assign pkt_done    = pkt_done_q;
  assign len_err     = len_err_q;
  assign pkt_count   = pkt_count_q;

endmodule
